// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared widths, destination/slot encodings and saturating counter helper for stream_demux.
package stream_demux_pkg;

    localparam int STAT_W = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

    typedef enum logic {
        DEST_OUT0 = 1'b0,
        DEST_OUT1 = 1'b1
    } dest_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
        return (c == STAT_MAX) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/stream_demux_if.sv
// stream_demux_if: producer and two consumer handshakes of stream_demux; STREAM_DEMUX_STATS_EN adds the per-output beat counters.
interface stream_demux_if #(parameter int WIDTH = 4);
    import stream_demux_pkg::*;
    logic [WIDTH-1:0] IN_DATA;
    logic             IN_VALID;
    logic             IN_READY;
    logic             SEL;
    logic [WIDTH-1:0] OUT0_DATA;
    logic             OUT0_VALID;
    logic             OUT0_READY;
    logic [WIDTH-1:0] OUT1_DATA;
    logic             OUT1_VALID;
    logic             OUT1_READY;
`ifdef STREAM_DEMUX_STATS_EN
    logic [STAT_W-1:0] STAT0_CNT;
    logic [STAT_W-1:0] STAT1_CNT;
`endif

    modport slave (
        input  IN_DATA, IN_VALID, SEL, OUT0_READY, OUT1_READY,
        output IN_READY, OUT0_DATA, OUT0_VALID, OUT1_DATA, OUT1_VALID
`ifdef STREAM_DEMUX_STATS_EN
        , output STAT0_CNT, STAT1_CNT
`endif
    );

    modport master (
        output IN_DATA, IN_VALID, SEL, OUT0_READY, OUT1_READY,
        input  IN_READY, OUT0_DATA, OUT0_VALID, OUT1_DATA, OUT1_VALID
`ifdef STREAM_DEMUX_STATS_EN
        , input STAT0_CNT, STAT1_CNT
`endif
    );

endinterface

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register with EMPTY/FULL state; a load while draining refills without a bubble.
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             can_load_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // load_i is only raised when can_load_o, so a FULL slot never loads while stalled
    always_comb begin
        can_load_o = (state_q == SLOT_EMPTY) | ready_i;
        state_d    = load_i ? SLOT_FULL : (ready_i ? SLOT_EMPTY : state_q);
        data_d     = load_i ? data_i : data_q;
    end

    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;

endmodule

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-2 valid/ready demultiplexer steered by SEL.
// Defining STREAM_DEMUX_STATS_EN adds saturating per-output accepted-beat counters.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic           CLK,
    input  logic           RST,
    stream_demux_if.slave  bus
);

    logic [1:0] can_load;
    logic [1:0] load;
    logic       in_fire;
    dest_e      dest;

    // IN_READY follows only the selected slot so a stalled consumer never blocks the other
    always_comb begin
        dest         = dest_e'(bus.SEL);
        bus.IN_READY = (dest == DEST_OUT1) ? can_load[1] : can_load[0];
        in_fire      = bus.IN_VALID & bus.IN_READY;
        load[0]      = in_fire & (dest == DEST_OUT0);
        load[1]      = in_fire & (dest == DEST_OUT1);
    end

    demux_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk        (CLK),
        .rst        (RST),
        .load_i     (load[0]),
        .data_i     (bus.IN_DATA),
        .ready_i    (bus.OUT0_READY),
        .can_load_o (can_load[0]),
        .valid_o    (bus.OUT0_VALID),
        .data_o     (bus.OUT0_DATA)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk        (CLK),
        .rst        (RST),
        .load_i     (load[1]),
        .data_i     (bus.IN_DATA),
        .ready_i    (bus.OUT1_READY),
        .can_load_o (can_load[1]),
        .valid_o    (bus.OUT1_VALID),
        .data_o     (bus.OUT1_DATA)
    );

`ifdef STREAM_DEMUX_STATS_EN
    logic [STAT_W-1:0] stat0_q, stat0_d, stat1_q, stat1_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    always_comb begin
        stat0_d = load[0] ? sat_inc(stat0_q) : stat0_q;
        stat1_d = load[1] ? sat_inc(stat1_q) : stat1_q;
    end

    assign bus.STAT0_CNT = stat0_q;
    assign bus.STAT1_CNT = stat1_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: vector table, directed corner sequences and a queue-model random run across WIDTH=1,4,5,6.
module tb_stream_demux;
    import stream_demux_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    stream_demux_if #(.WIDTH(1)) b1();
    stream_demux_if #(.WIDTH(4)) b4();
    stream_demux_if #(.WIDTH(5)) b5();
    stream_demux_if #(.WIDTH(6)) b6();

    stream_demux #(.WIDTH(1)) u1 (.CLK(CLK), .RST(RST), .bus(b1));
    stream_demux #(.WIDTH(4)) u4 (.CLK(CLK), .RST(RST), .bus(b4));
    stream_demux #(.WIDTH(5)) u5 (.CLK(CLK), .RST(RST), .bus(b5));
    stream_demux #(.WIDTH(6)) u6 (.CLK(CLK), .RST(RST), .bus(b6));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic       iv;
        logic       sel;
        logic [3:0] d;
        logic       r0;
        logic       r1;
        logic       exp_ir;
        logic       ev0;
        logic       ev1;
        logic [3:0] ed0;
        logic [3:0] ed1;
    } vec_t;

    vec_t vecs[8];

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    int         n0, n1;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 4'hF};
        vecs[1] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0};
        vecs[2] = '{1'b1, 1'b0, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h5, 4'h0};
        vecs[3] = '{1'b1, 1'b0, 4'hA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 4'h0};
        vecs[4] = '{1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 4'h3};
        vecs[5] = '{1'b1, 1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 4'h7};
        vecs[6] = '{1'b1, 1'b0, 4'h9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h9, 4'h7};
        vecs[7] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0};

        {b1.IN_VALID, b1.SEL, b1.IN_DATA, b1.OUT0_READY, b1.OUT1_READY} = 5'b00011;
        {b4.IN_VALID, b4.SEL, b4.IN_DATA, b4.OUT0_READY, b4.OUT1_READY} = 8'b00000011;
        {b5.IN_VALID, b5.SEL, b5.IN_DATA, b5.OUT0_READY, b5.OUT1_READY} = 9'b000000011;
        {b6.IN_VALID, b6.SEL, b6.IN_DATA, b6.OUT0_READY, b6.OUT1_READY} = 10'b0000000011;

        RST = 1'b1;
        repeat (2) step();
        chk("rst_held_valid", {b1.OUT0_VALID, b1.OUT1_VALID, b4.OUT0_VALID, b4.OUT1_VALID,
                               b5.OUT0_VALID, b5.OUT1_VALID, b6.OUT0_VALID, b6.OUT1_VALID}, 64'd0);
        RST = 1'b0;
        #1;
        chk("rst_w1", {b1.OUT0_VALID, b1.OUT1_VALID, b1.OUT0_DATA, b1.OUT1_DATA, b1.IN_READY}, 64'd1);
        chk("rst_w4", {b4.OUT0_VALID, b4.OUT1_VALID, b4.OUT0_DATA, b4.OUT1_DATA, b4.IN_READY}, 64'd1);
        chk("rst_w5", {b5.OUT0_VALID, b5.OUT1_VALID, b5.OUT0_DATA, b5.OUT1_DATA, b5.IN_READY}, 64'd1);
        chk("rst_w6", {b6.OUT0_VALID, b6.OUT1_VALID, b6.OUT0_DATA, b6.OUT1_DATA, b6.IN_READY}, 64'd1);
`ifdef STREAM_DEMUX_STATS_EN
        chk("rst_stat", {b4.STAT0_CNT, b4.STAT1_CNT}, 64'd0);
`endif
        step();

        for (int i = 0; i < 8; i++) begin
            b4.IN_VALID = vecs[i].iv;
            b4.SEL = vecs[i].sel;
            b4.IN_DATA = vecs[i].d;
            b4.OUT0_READY = vecs[i].r0;
            b4.OUT1_READY = vecs[i].r1;
            #1;
            chk($sformatf("w4_vec%0d_ir", i), b4.IN_READY, vecs[i].exp_ir);
            step();
            chk($sformatf("w4_vec%0d_valid", i), {b4.OUT0_VALID, b4.OUT1_VALID}, {vecs[i].ev0, vecs[i].ev1});
            if (vecs[i].ev0) chk($sformatf("w4_vec%0d_d0", i), b4.OUT0_DATA, vecs[i].ed0);
            if (vecs[i].ev1) chk($sformatf("w4_vec%0d_d1", i), b4.OUT1_DATA, vecs[i].ed1);
        end
        b4.IN_VALID = 1'b0;

        b5.OUT0_READY = 1'b0;
        b5.IN_VALID = 1'b1;
        b5.SEL = 1'b0;
        b5.IN_DATA = 5'b10111;
        step();
        chk("w5_bp_v0", b5.OUT0_VALID, 1'b1);
        chk("w5_bp_d0", b5.OUT0_DATA, 5'b10111);
        chk("w5_bp_ir_sel0", b5.IN_READY, 1'b0);
        b5.SEL = 1'b1;
        b5.IN_DATA = 5'b00001;
        #1;
        chk("w5_bp_ir_sel1", b5.IN_READY, 1'b1);
        step();
        b5.IN_VALID = 1'b0;
        chk("w5_bp_v1", {b5.OUT1_VALID, b5.OUT1_DATA}, {1'b1, 5'b00001});
        chk("w5_bp_stall0", {b5.OUT0_VALID, b5.OUT0_DATA}, {1'b1, 5'b10111});
        step();
        chk("w5_bp_still0", {b5.OUT0_VALID, b5.OUT0_DATA, b5.OUT1_VALID}, {1'b1, 5'b10111, 1'b0});
        b5.OUT0_READY = 1'b1;
        step();

        b6.OUT0_READY = 1'b1;
        b6.SEL = 1'b0;
        b6.IN_VALID = 1'b1;
        b6.IN_DATA = 6'b101011;
        step();
        chk("w6_tp_beat0", {b6.OUT0_VALID, b6.OUT0_DATA}, {1'b1, 6'b101011});
        b6.IN_DATA = 6'b010100;
        #1;
        chk("w6_tp_ir", b6.IN_READY, 1'b1);
        step();
        chk("w6_tp_beat1", {b6.OUT0_VALID, b6.OUT0_DATA}, {1'b1, 6'b010100});
        b6.IN_DATA = 6'b111000;
        step();
        chk("w6_tp_beat2", {b6.OUT0_VALID, b6.OUT0_DATA}, {1'b1, 6'b111000});
        b6.IN_VALID = 1'b0;
        step();
        chk("w6_tp_drain", b6.OUT0_VALID, 1'b0);

        b1.OUT1_READY = 1'b0;
        b1.IN_VALID = 1'b1;
        b1.SEL = 1'b1;
        b1.IN_DATA = 1'b1;
        step();
        b1.IN_VALID = 1'b0;
        b1.SEL = 1'bx;
        b1.IN_DATA = 1'bx;
        repeat (3) step();
        chk("w1_selx_valid", {b1.OUT0_VALID, b1.OUT1_VALID, b1.OUT1_DATA}, {1'b0, 1'b1, 1'b1});
        chk("w1_selx_known", $isunknown({b1.OUT0_VALID, b1.OUT1_VALID}), 1'b0);

        b4.OUT0_READY = 1'b0;
        b4.IN_VALID = 1'b1;
        b4.SEL = 1'b0;
        b4.IN_DATA = 4'hC;
        step();
        b4.IN_VALID = 1'b0;
        chk("mid_pre_v0", b4.OUT0_VALID, 1'b1);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("mid_async_clear", {b4.OUT0_VALID, b4.OUT1_VALID, b1.OUT1_VALID, b5.OUT0_VALID}, 64'd0);
`ifdef STREAM_DEMUX_STATS_EN
        chk("mid_stat0", b4.STAT0_CNT, 16'd0);
`endif
        step();
        RST = 1'b0;
        b1.SEL = 1'b0;
        b1.OUT1_READY = 1'b1;
        b4.OUT0_READY = 1'b1;
        step();
        chk("mid_no_pulse", {b4.OUT0_VALID, b4.OUT1_VALID, b4.IN_READY}, {1'b0, 1'b0, 1'b1});

        q0.delete();
        q1.delete();
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 300; c++) begin
            logic exp_ir;
            b6.IN_VALID = $urandom_range(0, 3) != 0;
            b6.SEL = 1'($urandom);
            b6.IN_DATA = 6'($urandom);
            b6.OUT0_READY = $urandom_range(0, 2) != 0;
            b6.OUT1_READY = $urandom_range(0, 3) == 0;
            #1;
            exp_ir = b6.SEL ? (q1.size() == 0 || b6.OUT1_READY) : (q0.size() == 0 || b6.OUT0_READY);
            chk($sformatf("rnd%0d_ir", c), b6.IN_READY, exp_ir);
            if (b6.OUT0_READY && q0.size() != 0) void'(q0.pop_front());
            if (b6.OUT1_READY && q1.size() != 0) void'(q1.pop_front());
            if (b6.IN_VALID && exp_ir) begin
                if (b6.SEL) begin
                    q1.push_back(b6.IN_DATA);
                    n1 = (n1 < 65535) ? n1 + 1 : n1;
                end else begin
                    q0.push_back(b6.IN_DATA);
                    n0 = (n0 < 65535) ? n0 + 1 : n0;
                end
            end
            step();
            chk($sformatf("rnd%0d_valid", c), {b6.OUT0_VALID, b6.OUT1_VALID}, {q0.size() != 0, q1.size() != 0});
            if (q0.size() != 0) chk($sformatf("rnd%0d_d0", c), b6.OUT0_DATA, q0[0]);
            if (q1.size() != 0) chk($sformatf("rnd%0d_d1", c), b6.OUT1_DATA, q1[0]);
`ifdef STREAM_DEMUX_STATS_EN
            chk($sformatf("rnd%0d_stat", c), {b6.STAT0_CNT, b6.STAT1_CNT}, {16'(n0), 16'(n1)});
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
